// File: rtl/kernel_rr_sched_pkg.sv
// Shared defaults, counter widths and FSM encoding for the round-robin kernel scheduler.
package kernel_rr_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned W_DEF     = 32;
  localparam int unsigned RST_CNT_W = 4;
  localparam int unsigned RUN_CNT_W = 24;

  // Scheduler state encoding (IDLE -> KRST -> RUN -> RESP -> IDLE).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_KRST = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/kernel_rr_sched_if.sv
// Request, response and kernel-control bundle of the kernel scheduler.
interface kernel_rr_sched_if
  import kernel_rr_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
);
  localparam int unsigned ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_n;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              kern_rst_n;
  logic              kern_start;
  logic [W-1:0]      kern_n;
  logic              kern_finish;
  logic [W-1:0]      kern_ret;
  logic              busy;

  modport slave (
    input  req_valid, req_n, rsp_ready, kern_finish, kern_ret,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           kern_rst_n, kern_start, kern_n, busy
  );

  modport master (
    output req_valid, req_n, rsp_ready, kern_finish, kern_ret,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           kern_rst_n, kern_start, kern_n, busy
  );
endinterface

// File: rtl/kernel_rr_sched_rr_arbiter.sv
// Circular-priority selector: first set request at or after ptr wins.
module rr_arbiter
  import kernel_rr_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int unsigned IDX_W = $clog2(NREQ);

  // NREQ is a power of two, so ptr + i wraps naturally.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[ptr + IDX_W'(i)]) begin
        any = 1'b1;
        idx = ptr + IDX_W'(i);
      end
    end
    grant = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/kernel_rr_sched.sv
// Round-robin job scheduler: grants one requester, resets and runs a shared kernel, returns its result.
module kernel_rr_sched
  import kernel_rr_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic              clk,
  input logic              rst_n,
  kernel_rr_sched_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NREQ);

  state_t                state, state_d;
  logic [ID_W-1:0]       rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [W-1:0]          op_d;
  logic [RST_CNT_W-1:0]  rst_cnt, rst_cnt_d;
  logic [RUN_CNT_W-1:0]  run_cnt, run_cnt_d;
  logic                  rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_d;
  logic [W-1:0]          rsp_data_d;
  logic                  rsp_err_d;

  logic [NREQ-1:0]       arb_grant;
  logic [ID_W-1:0]       arb_idx;
  logic                  arb_any;
  logic [W-1:0]          arb_op;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign arb_op = bus.req_n[32'(arb_idx) * W +: W];

  // Accept is only offered from IDLE and is suppressed while reset is applied.
  assign bus.req_ready = (state == ST_IDLE && rst_n) ? arb_grant : '0;

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    id_d        = id_q;
    op_d        = bus.kern_n;
    rst_cnt_d   = rst_cnt;
    run_cnt_d   = run_cnt;
    rsp_valid_d = bus.rsp_valid;
    rsp_id_d    = bus.rsp_id;
    rsp_data_d  = bus.rsp_data;
    rsp_err_d   = bus.rsp_err;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          id_d      = arb_idx;
          op_d      = arb_op;
          rr_ptr_d  = arb_idx + ID_W'(1);
          rst_cnt_d = '0;
          state_d   = ST_KRST;
        end
      end
      ST_KRST: begin
        if (rst_cnt == RST_CNT_W'(RST_CYC - 1)) begin
          run_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt + RST_CNT_W'(1);
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt + RUN_CNT_W'(1);
        // First RUN cycle ignores a finish left over from the previous job.
        if (bus.kern_finish && run_cnt != '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = bus.kern_ret;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (run_cnt == RUN_CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      id_q           <= '0;
      rst_cnt        <= '0;
      run_cnt        <= '0;
      bus.kern_n     <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_err    <= 1'b0;
      bus.kern_rst_n <= 1'b0;
      bus.kern_start <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      rr_ptr         <= rr_ptr_d;
      id_q           <= id_d;
      rst_cnt        <= rst_cnt_d;
      run_cnt        <= run_cnt_d;
      bus.kern_n     <= op_d;
      bus.rsp_valid  <= rsp_valid_d;
      bus.rsp_id     <= rsp_id_d;
      bus.rsp_data   <= rsp_data_d;
      bus.rsp_err    <= rsp_err_d;
      bus.kern_rst_n <= (state_d == ST_RUN);
      bus.kern_start <= (state_d == ST_RUN);
      bus.busy       <= (state_d != ST_IDLE);
    end
  end
endmodule

// File: doc/kernel_rr_sched.md
KERNEL_RR_SCHED -- requirements
Module: kernel_rr_sched

Parameters
REQ-001 NREQ, default 4: number of requesters; power of two, 2..8.
REQ-002 W, default 32: width of operand and result.
REQ-003 RST_CYC, default 2: number of kernel-reset cycles per job; 1..15.
REQ-004 TIMEOUT, default 65535: RUN-cycle limit per job; 1..2^24-1.

Interface
REQ-005 Reset is rst_n, synchronous, active-low; the clock is clk.
REQ-006 clk  in  1  clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_valid  in  NREQ  per-requester job request.
REQ-009 req_n  in  NREQ*W  per-requester operand; slice i belongs to requester i.
REQ-010 req_ready  out  NREQ  one-hot accept; the job transfers when valid and ready are both high.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  result consumer accepts.
REQ-013 rsp_id  out  clog2(NREQ)  requester index of the result.
REQ-014 rsp_data  out  W  kernel result (step count).
REQ-015 rsp_err  out  1  job timed out.
REQ-016 kern_rst_n  out  1  kernel reset, active-low.
REQ-017 kern_start  out  1  kernel start.
REQ-018 kern_n  out  W  kernel operand.
REQ-019 kern_finish  in  1  kernel done; sticky until the kernel is reset.
REQ-020 kern_ret  in  W  kernel result.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, KRST, RUN and RESP, held in a registered state variable.
REQ-023 IDLE: when any req_valid is high, the grant SHALL go to the first valid index at or after rr_ptr (circular search).
- req_ready is asserted one-hot for the granted index in that same cycle (combinational from state, req_valid and rr_ptr).
- req_n and the index are latched.
- rr_ptr becomes grant+1 mod NREQ.
- The FSM moves to KRST.
REQ-024 KRST SHALL last exactly RST_CYC cycles, counted by a cycle counter, and then move to RUN.
REQ-025 kern_rst_n SHALL be high only in RUN; kern_start SHALL be high only in RUN; kern_n SHALL hold the latched operand in KRST and RUN.
REQ-026 RUN: a W-bit-independent 24-bit counter SHALL start at 0 and increment each cycle.
- If kern_finish is high: kern_ret is captured into rsp_data, rsp_err is set to 0, and the FSM moves to RESP.
- Otherwise, if the counter equals TIMEOUT-1: rsp_data is set to 0, rsp_err to 1, and the FSM moves to RESP.
- kern_finish takes priority over timeout in the same cycle.
REQ-027 The kern_finish input SHALL be ignored in the first RUN cycle, to mask the kernel's stale finish from the previous job.
REQ-028 RESP: rsp_valid SHALL be high and rsp_id/rsp_data/rsp_err SHALL be stable until rsp_ready is high; the FSM then moves to IDLE.
REQ-029 A new grant SHALL never occur in the RESP-to-IDLE transfer cycle; one IDLE bubble is mandatory.
REQ-030 A requester dropping req_valid while not granted SHALL have no effect; req_valid SHALL only be sampled in IDLE.
REQ-031 Job latency (grant to rsp_valid) SHALL be RST_CYC + 1 + k cycles, where k is the kernel compute time in RUN cycles.

Reset
REQ-032 Reset SHALL force the following, and SHALL take effect mid-job from any state with no response emitted:
- state = IDLE
- rr_ptr = 0
- counters = 0
- rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_id = 0
- kern_rst_n = 0, kern_start = 0, kern_n = 0
- req_ready = 0, busy = 0

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the defaults for W and NREQ.
REQ-034 The round-robin selector SHALL be a sub-module, rr_arbiter, with inputs (req, ptr) and outputs (one-hot grant, index, any).

Verification
REQ-035 Single job: n=6 on requester 2 with a real collatz kernel -> rsp_id=2, rsp_data=8, rsp_err=0; kern_rst_n low for exactly 2 cycles before RUN.
REQ-036 Fairness: all 4 requesters hold req_valid with n=1..4 -> grant order 0,1,2,3; then again 0; the rsp_data sequence is 0,1,7,2.
REQ-037 Timeout: TIMEOUT=10 and a stub kernel that never finishes -> rsp_err=1, rsp_data=0 after exactly 10 RUN cycles.
REQ-038 Backpressure: rsp_ready held low for 20 cycles -> rsp fields stable, no new req_ready, and the grant occurs 1 cycle after acceptance.
REQ-039 Stale finish: the stub kernel's kern_finish is held high through reset -> the first RUN cycle is ignored and the result is captured on the second RUN cycle.
REQ-040 Mid-job reset: rst_n is asserted in RUN -> next cycle IDLE, busy=0, no rsp_valid, rr_ptr=0.
